// File: rtl/ecc_scrubber.sv
// Background scrubber for a Hamming SEC-DED protected register file: walks every word,
// writes back single-bit corrections and counts/flags uncorrectable words.
module ecc_scrubber #(
    parameter int WORD_SIZE    = 32,
    parameter int ECCBITS      = 7,
    parameter int REGISTERS    = 32,
    parameter int REGDIRSIZE   = 5,
    parameter int COUNTERSIZE  = 32,
    parameter int INTERVALBITS = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [INTERVALBITS-1:0]       interval_i,
    input  logic                          user_valid_i,
    input  logic                          user_we_i,
    input  logic [REGDIRSIZE-1:0]         user_addr_i,
    output logic                          scrub_req_o,
    output logic                          scrub_we_o,
    output logic [REGDIRSIZE-1:0]         scrub_addr_o,
    output logic [WORD_SIZE+ECCBITS-1:0]  scrub_wdata_o,
    input  logic                          scrub_gnt_i,
    input  logic [WORD_SIZE+ECCBITS-1:0]  scrub_rdata_i,
    output logic [COUNTERSIZE-1:0]        corrected_cnt_o,
    output logic [COUNTERSIZE-1:0]        uncorrectable_cnt_o,
    output logic [REGDIRSIZE-1:0]         err_addr_o,
    output logic                          uncorrectable_o,
    output logic                          pass_done_o
);
    localparam int PBITS   = ECCBITS - 1;
    localparam int CW      = WORD_SIZE + ECCBITS;
    localparam int MAX_POS = WORD_SIZE + PBITS;
    localparam logic [REGDIRSIZE-1:0] LAST_ADDR = REGDIRSIZE'(REGISTERS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;

    // Hamming position of data bit k: the (k+1)-th position that is not a power of two.
    function automatic logic [PBITS-1:0] hpos(input int k);
        int n;
        logic [PBITS-1:0] r;
        n = 0;
        r = '0;
        for (int pos = 1; pos < 2 ** PBITS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == k) r = PBITS'(pos);
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [PBITS-1:0] check_bits(input logic [WORD_SIZE-1:0] d);
        logic [PBITS-1:0] c;
        logic [PBITS-1:0] p;
        c = '0;
        for (int k = 0; k < WORD_SIZE; k++) begin
            p = hpos(k);
            for (int i = 0; i < PBITS; i++) begin
                if (p[i]) c[i] = c[i] ^ d[k];
            end
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [WORD_SIZE-1:0] d);
        logic [PBITS-1:0] c;
        c = check_bits(d);
        return {(^d) ^ (^c), c, d};
    endfunction

    logic [2:0]              state, state_next;
    logic [REGDIRSIZE-1:0]   addr;
    logic [INTERVALBITS-1:0] wait_cnt;
    logic [CW-1:0]           wdata;

    logic [WORD_SIZE-1:0] rd_data, fixed_data;
    logic [PBITS-1:0]     syn;
    logic                 par, is_clean, is_correctable;
    logic                 grant, user_wr_hit, at_last;
    logic                 load_cnt, do_advance, count_corr, count_uncorr, capture;

    assign scrub_req_o   = ((state == S_RD) || (state == S_WR)) && !user_valid_i;
    assign scrub_we_o    = (state == S_WR);
    assign scrub_addr_o  = addr;
    assign scrub_wdata_o = wdata;
    assign grant         = scrub_req_o && scrub_gnt_i;
    assign user_wr_hit   = user_valid_i && user_we_i && (user_addr_i == addr);
    assign at_last       = (addr == LAST_ADDR);

    always_comb begin
        rd_data        = scrub_rdata_i[WORD_SIZE-1:0];
        syn            = check_bits(rd_data) ^ scrub_rdata_i[CW-2:WORD_SIZE];
        par            = ^scrub_rdata_i;
        fixed_data     = rd_data;
        for (int k = 0; k < WORD_SIZE; k++) begin
            if (syn == hpos(k)) fixed_data[k] = ~rd_data[k];
        end
        is_clean       = (syn == '0) && !par;
        // Odd parity with a syndrome inside the codeword is exactly one flipped bit.
        is_correctable = par && (int'(syn) <= MAX_POS);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next   = state;
        load_cnt     = 1'b0;
        do_advance   = 1'b0;
        count_corr   = 1'b0;
        count_uncorr = 1'b0;
        capture      = 1'b0;
        case (state)
            S_IDLE: if (enable_i) begin
                state_next = S_WAIT;
                load_cnt   = 1'b1;
            end
            S_WAIT: begin
                if (!enable_i)                            state_next = S_IDLE;
                else if (wait_cnt <= INTERVALBITS'(1))    state_next = S_RD;
            end
            S_RD: begin
                if (grant)          state_next = S_CHK;
                else if (!enable_i) state_next = S_IDLE;
            end
            S_CHK: begin
                if (is_clean) begin
                    do_advance = 1'b1;
                end else if (is_correctable) begin
                    if (user_wr_hit) begin
                        do_advance = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_WR;
                    end
                end else begin
                    count_uncorr = 1'b1;
                    do_advance   = 1'b1;
                end
            end
            S_WR: begin
                if (user_wr_hit) begin
                    do_advance = 1'b1;
                end else if (grant) begin
                    count_corr = 1'b1;
                    do_advance = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (do_advance) begin
            state_next = S_WAIT;
            load_cnt   = 1'b1;
        end
    end

    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block only.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state               <= S_IDLE;
            addr                <= '0;
            wait_cnt            <= '0;
            wdata               <= '0;
            corrected_cnt_o     <= '0;
            uncorrectable_cnt_o <= '0;
            err_addr_o          <= '0;
            uncorrectable_o     <= 1'b0;
            pass_done_o         <= 1'b0;
        end else begin
            state           <= state_next;
            uncorrectable_o <= count_uncorr;
            pass_done_o     <= do_advance && at_last;
            if (load_cnt)
                wait_cnt <= interval_i;
            else if ((state == S_WAIT) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - INTERVALBITS'(1);
            if (capture) wdata <= encode(fixed_data);
            if (do_advance) addr <= at_last ? '0 : addr + REGDIRSIZE'(1);
            if (count_uncorr) begin
                err_addr_o <= addr;
                if (uncorrectable_cnt_o != '1)
                    uncorrectable_cnt_o <= uncorrectable_cnt_o + COUNTERSIZE'(1);
            end
            if (count_corr && (corrected_cnt_o != '1))
                corrected_cnt_o <= corrected_cnt_o + COUNTERSIZE'(1);
        end
    end
endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber: behavioural register file on the scrub port,
// table of single-pass corruption cases plus hand sequences for gating, abort and reset.
module tb_ecc_scrubber;
    localparam int CW    = 39;
    localparam int CNT_W = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              enable_i = 1'b0;
    logic [15:0]       interval_i = '0;
    logic              user_valid_i = 1'b0;
    logic              user_we_i = 1'b0;
    logic [4:0]        user_addr_i = '0;
    logic              scrub_req_o, scrub_we_o;
    logic [4:0]        scrub_addr_o;
    logic [CW-1:0]     scrub_wdata_o;
    logic              scrub_gnt_i = 1'b1;
    logic [CW-1:0]     scrub_rdata_i;
    logic [CNT_W-1:0]  corrected_cnt_o, uncorrectable_cnt_o;
    logic [4:0]        err_addr_o;
    logic              uncorrectable_o, pass_done_o;

    always #5 clk_i = ~clk_i;

    ecc_scrubber #(.COUNTERSIZE(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .interval_i(interval_i),
        .user_valid_i(user_valid_i), .user_we_i(user_we_i), .user_addr_i(user_addr_i),
        .scrub_req_o(scrub_req_o), .scrub_we_o(scrub_we_o), .scrub_addr_o(scrub_addr_o),
        .scrub_wdata_o(scrub_wdata_o), .scrub_gnt_i(scrub_gnt_i), .scrub_rdata_i(scrub_rdata_i),
        .corrected_cnt_o(corrected_cnt_o), .uncorrectable_cnt_o(uncorrectable_cnt_o),
        .err_addr_o(err_addr_o), .uncorrectable_o(uncorrectable_o), .pass_done_o(pass_done_o)
    );

    logic [CW-1:0] mem [32];
    logic [CW-1:0] rdata_q = '0;
    int            cycle = 0;
    int            rd_log[$];
    int            rd_time[$];
    int            wr_addr_log[$];
    logic [CW-1:0] wr_data_log[$];
    int            pass_pulses = 0;
    int            unc_pulses = 0;
    int            total = 0;
    int            bad = 0;

    assign scrub_rdata_i = rdata_q;

    // Register-file model and event monitor on the scrub port.
    always @(posedge clk_i) begin
        cycle++;
        if (scrub_req_o && scrub_gnt_i) begin
            if (scrub_we_o) begin
                mem[scrub_addr_o] <= scrub_wdata_o;
                wr_addr_log.push_back(int'(scrub_addr_o));
                wr_data_log.push_back(scrub_wdata_o);
            end else begin
                rdata_q <= mem[scrub_addr_o];
                rd_log.push_back(int'(scrub_addr_o));
                rd_time.push_back(cycle);
            end
        end
        if (pass_done_o) pass_pulses++;
        if (uncorrectable_o) unc_pulses++;
    end

    // Reference encoder: scatter data into Hamming positions 1..38, then take parity per position bit.
    function automatic logic [CW-1:0] tb_enc(input logic [31:0] d);
        logic [38:1] h;
        logic [5:0]  c;
        int          k;
        h = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!(pos inside {1, 2, 4, 8, 16, 32})) begin
                h[pos] = d[k];
                k++;
            end
        end
        c = '0;
        for (int i = 0; i < 6; i++)
            for (int pos = 1; pos <= 38; pos++)
                if (pos[i]) c[i] = c[i] ^ h[pos];
        return {(^d) ^ (^c), c, d};
    endfunction

    function automatic logic [31:0] pat(input int a);
        return (32'(a) << 27) | 32'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        rd_time.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        pass_pulses = 0;
        unc_pulses  = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        enable_i = 1'b0;
        user_valid_i = 1'b0;
        user_we_i = 1'b0;
        user_addr_i = '0;
        scrub_gnt_i = 1'b1;
        interval_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        clear_logs();
        rst_i = 1'b1;
    endtask

    task automatic fill_mem();
        for (int a = 0; a < 32; a++) mem[a] = tb_enc(pat(a));
    endtask

    task automatic run_pass(input string name);
        bit seen;
        seen = 1'b0;
        enable_i = 1'b1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk_i);
            #1;
            if (pass_done_o) seen = 1'b1;
        end
        enable_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check({name, " pass_done seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_req(input logic we, input int a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (scrub_req_o && (scrub_we_o == we) && (int'(scrub_addr_o) == a)) ok = 1'b1;
            else begin
                @(posedge clk_i);
                #1;
            end
        end
    endtask

    typedef struct {
        int            addr;
        logic [CW-1:0] mask;
        int            exp_wr;
        int            exp_cc;
        int            exp_uc;
        int            exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit            ok;
        int            order_bad;
        int            low;
        logic [CW-1:0] corrupted;
        string         nm;

        vecs[0] = '{0,  39'h00_0000_0000, 0, 0, 0, 0};   // all clean
        vecs[1] = '{5,  39'h00_0000_0001, 1, 1, 0, 0};   // data bit 0
        vecs[2] = '{9,  39'h40_0000_0000, 1, 1, 0, 0};   // c6 only
        vecs[3] = '{7,  39'h00_0000_0003, 0, 0, 1, 7};   // two data bits
        vecs[4] = '{31, 39'h02_0000_0000, 1, 1, 0, 0};   // c1, last address
        vecs[5] = '{0,  39'h00_8000_0000, 1, 1, 0, 0};   // data bit 31 (position 38)
        vecs[6] = '{12, 39'h40_0000_0001, 0, 0, 1, 12};  // c6 plus data bit 0
        vecs[7] = '{20, 39'h00_8000_0011, 0, 0, 1, 20};  // syndrome 44 with odd parity

        do_reset();
        check("reset req", 64'(scrub_req_o), 64'd0);
        check("reset we", 64'(scrub_we_o), 64'd0);
        check("reset addr", 64'(scrub_addr_o), 64'd0);
        check("reset wdata", 64'(scrub_wdata_o), 64'd0);
        check("reset counters", 64'({corrected_cnt_o, uncorrectable_cnt_o}), 64'd0);
        check("reset err_addr", 64'(err_addr_o), 64'd0);
        check("reset pulses", 64'({uncorrectable_o, pass_done_o}), 64'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            fill_mem();
            mem[vecs[v].addr] = mem[vecs[v].addr] ^ vecs[v].mask;
            corrupted = mem[vecs[v].addr];
            nm = $sformatf("vec%0d", v);
            run_pass(nm);
            order_bad = 0;
            for (int i = 0; i < 32; i++)
                if (i >= rd_log.size() || rd_log[i] != i) order_bad++;
            check({nm, " read order"}, 64'(order_bad), 64'd0);
            check({nm, " read count"}, 64'(rd_log.size()), 64'd32);
            check({nm, " read period"}, 64'(rd_time[11] - rd_time[10]), 64'd3);
            check({nm, " writes"}, 64'(wr_addr_log.size()), 64'(vecs[v].exp_wr));
            check({nm, " corrected_cnt"}, 64'(corrected_cnt_o), 64'(vecs[v].exp_cc));
            check({nm, " uncorrectable_cnt"}, 64'(uncorrectable_cnt_o), 64'(vecs[v].exp_uc));
            check({nm, " err_addr"}, 64'(err_addr_o), 64'(vecs[v].exp_err));
            check({nm, " unc pulses"}, 64'(unc_pulses), 64'(vecs[v].exp_uc));
            check({nm, " pass pulses"}, 64'(pass_pulses), 64'd1);
            check({nm, " word after pass"}, 64'(mem[vecs[v].addr]),
                  64'((vecs[v].exp_cc != 0) ? tb_enc(pat(vecs[v].addr)) : corrupted));
            if (vecs[v].exp_wr == 1) begin
                check({nm, " write addr"}, 64'(wr_addr_log[0]), 64'(vecs[v].addr));
                if (vecs[v].addr == 5)
                    check({nm, " write data"}, 64'(wr_data_log[0]), 64'h03_2800_0005);
            end
        end

        // User write to the word under check cancels its write-back.
        do_reset();
        fill_mem();
        mem[5] = mem[5] ^ 39'h1;
        enable_i = 1'b1;
        wait_req(1'b0, 5, ok);
        check("abort reach rd5", 64'(ok), 64'd1);
        @(posedge clk_i);
        #1;
        user_valid_i = 1'b1;
        user_we_i = 1'b1;
        user_addr_i = 5'd5;
        @(posedge clk_i);
        #1;
        user_valid_i = 1'b0;
        user_we_i = 1'b0;
        run_pass("abort");
        check("abort writes", 64'(wr_addr_log.size()), 64'd0);
        check("abort corrected_cnt", 64'(corrected_cnt_o), 64'd0);
        check("abort next read", 64'((rd_log.size() > 6) ? rd_log[6] : -1), 64'd6);

        // User traffic blocks the read request; interval 3 gives a 5-cycle read period.
        do_reset();
        fill_mem();
        scrub_gnt_i = 1'b0;
        enable_i = 1'b1;
        wait_req(1'b0, 0, ok);
        check("gate reach rd0", 64'(ok), 64'd1);
        user_valid_i = 1'b1;
        user_addr_i = 5'd9;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!scrub_req_o) low++;
            @(posedge clk_i);
            #1;
        end
        check("gate req low cycles", 64'(low), 64'd10);
        user_valid_i = 1'b0;
        interval_i = 16'd3;
        #1;
        check("gate req resumes", 64'(scrub_req_o), 64'd1);
        scrub_gnt_i = 1'b1;
        for (int i = 0; i < 200 && rd_log.size() < 3; i++) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        check("gate reads done", 64'(rd_log.size() >= 3), 64'd1);
        check("gate first read addr", 64'(rd_log[0]), 64'd0);
        check("interval3 period", 64'(rd_time[1] - rd_time[0]), 64'd5);

        // Reset in the middle of a pending write-back.
        do_reset();
        fill_mem();
        mem[3] = mem[3] ^ 39'h20;
        corrupted = mem[3];
        enable_i = 1'b1;
        wait_req(1'b0, 3, ok);
        check("rstwr reach rd3", 64'(ok), 64'd1);
        @(posedge clk_i);
        #1;
        scrub_gnt_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rstwr in write", 64'({scrub_req_o, scrub_we_o, scrub_addr_o}), 64'({1'b1, 1'b1, 5'd3}));
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rstwr outputs", 64'({scrub_req_o, scrub_we_o, scrub_addr_o, err_addr_o,
                                    uncorrectable_o, pass_done_o}), 64'd0);
        check("rstwr wdata", 64'(scrub_wdata_o), 64'd0);
        check("rstwr counters", 64'({corrected_cnt_o, uncorrectable_cnt_o}), 64'd0);
        clear_logs();
        rst_i = 1'b1;
        scrub_gnt_i = 1'b1;
        for (int i = 0; i < 200 && rd_log.size() < 1; i++) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        check("rstwr restart addr", 64'((rd_log.size() > 0) ? rd_log[0] : -1), 64'd0);
        check("rstwr no write", 64'(wr_addr_log.size()), 64'd0);
        check("rstwr word untouched", 64'(mem[3]), 64'(corrupted));

        // Four uncorrectable words on a 2-bit counter: saturates at 3.
        do_reset();
        fill_mem();
        for (int a = 2; a <= 8; a += 2) mem[a] = mem[a] ^ 39'h3;
        run_pass("sat");
        check("sat uncorrectable_cnt", 64'(uncorrectable_cnt_o), 64'd3);
        check("sat unc pulses", 64'(unc_pulses), 64'd4);
        check("sat err_addr", 64'(err_addr_o), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
